mult_seq_ctrl: RTL and testbench

Operand sequencer that sits directly upstream of the 16-bit sequential shift-add multiplier. It buffers operand pairs from a valid/ready producer in a small FIFO and drives the multiplier's clear/start controls and operands. It counts the multiplier's fixed latency, captures the 32-bit product and presents it on a valid/ready result port. The multiplier itself has no done flag, so this block is the only thing that knows when its product is valid.

---
 rtl/mult_seq_pkg.sv | 22 ++
 rtl/mult_seq_fifo.sv | 48 ++++
 rtl/mult_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_mult_seq_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_seq_pkg.sv
// Shared types and widths for the mult_seq_ctrl operand sequencer.
// Optional feature macro: MULT_SEQ_ZERO_SKIP_EN (see mult_seq_ctrl.sv).
package mult_seq_pkg;

  localparam int OP_W   = 16;
  localparam int PROD_W = 32;
  localparam int CNT_W  = 6;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    START,
    WAIT,
    HOLD
  } state_t;

  // A FIFO entry is {a, b}; either operand being zero makes the product zero.
  function automatic logic is_zero_pair(input logic [2*OP_W-1:0] entry);
    return (entry[2*OP_W-1:OP_W] == '0) || (entry[OP_W-1:0] == '0);
  endfunction

endpackage

// File: rtl/mult_seq_fifo.sv
// Synchronous operand FIFO; pointers carry one extra wrap bit so full and
// empty are distinguishable without a separate counter.
module mult_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] fill
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fill    = wr_ptr - rd_ptr;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Operand sequencer for the 16-bit shift-add multiplier: buffers pairs, pulses
// clear/start, times the fixed latency and holds the product for the consumer.
// Define MULT_SEQ_ZERO_SKIP_EN to bypass the multiplier for zero operands.
module mult_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int MUL_LATENCY = 33
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OP_W-1:0]        in_a,
  input  logic [OP_W-1:0]        in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PROD_W-1:0]      out_product,
  output logic [OP_W-1:0]        mul_a,
  output logic [OP_W-1:0]        mul_b,
  output logic                   mul_clear,
  output logic                   mul_start,
  input  logic [PROD_W-1:0]      mul_product,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fill
);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*OP_W-1:0]  head;
  logic               full;
  logic               empty;
  logic               pop;
  logic               load_ops;
  logic               capture;
  logic               skip;

  mult_seq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2*OP_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_valid),
    .push_data ({in_a, in_b}),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .fill      (fill)
  );

  assign in_ready  = !full;
  assign mul_clear = (state == CLEAR);
  assign mul_start = (state == START);
  assign busy      = (state != IDLE) || !empty;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load_ops  = 1'b0;
    capture   = 1'b0;
    skip      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !out_valid) begin
`ifdef MULT_SEQ_ZERO_SKIP_EN
          if (is_zero_pair(head)) begin
            skip      = 1'b1;
            pop       = 1'b1;
            state_nxt = HOLD;
          end else begin
            load_ops  = 1'b1;
            state_nxt = CLEAR;
          end
`else
          load_ops  = 1'b1;
          state_nxt = CLEAR;
`endif
        end
      end
      CLEAR: begin
        pop       = 1'b1;
        state_nxt = START;
      end
      START: state_nxt = WAIT;
      WAIT: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_valid && out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are registered on the way into CLEAR so they are already on
  // mul_a/mul_b during the clear pulse and stay frozen until the next one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      out_product <= '0;
      out_valid   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_ops) {mul_a, mul_b} <= head;
      if (state == START) begin
        cnt <= CNT_W'(MUL_LATENCY - 1);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (capture) begin
        out_product <= mul_product;
        out_valid   <= 1'b1;
      end else if (skip) begin
        out_product <= '0;
        out_valid   <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl with a behavioural multiplier that only
// presents a correct product once its latency has elapsed after start.
module tb_mult_seq_ctrl;

  localparam int DEPTH = 4;
  localparam int L     = 33;
  localparam int FW    = $clog2(DEPTH) + 1;
  localparam int NRAND = 20;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] prod;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_a;
  logic [15:0]   in_b;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_product;
  logic [15:0]   mul_a;
  logic [15:0]   mul_b;
  logic          mul_clear;
  logic          mul_start;
  logic [31:0]   mul_product;
  logic          busy;
  logic [FW-1:0] fill;

  int checks = 0;
  int errors = 0;

  mult_seq_ctrl #(
    .DEPTH       (DEPTH),
    .MUL_LATENCY (L)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_clear   (mul_clear),
    .mul_start   (mul_start),
    .mul_product (mul_product),
    .busy        (busy),
    .fill        (fill)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: wrong value until L-1 edges after start, or if the operands move.
  logic [15:0] lat_a = '0;
  logic [15:0] lat_b = '0;
  logic        armed = 1'b0;
  int          since = 0;
  logic [31:0] true_prod;

  always @(posedge clk) begin
    if (mul_start) begin
      lat_a <= mul_a;
      lat_b <= mul_b;
      armed <= 1'b1;
      since <= 0;
    end else begin
      if (mul_clear) armed <= 1'b0;
      if (since < 1000) since <= since + 1;
    end
  end

  assign true_prod   = 32'(lat_a) * 32'(lat_b);
  assign mul_product = (armed && since >= L - 1 && mul_a == lat_a && mul_b == lat_b)
                       ? true_prod : ~true_prod;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      check("inv_clear_start_exclusive", mul_clear && mul_start, 1'b0);
      check("inv_in_ready_not_full", in_ready, fill != FW'(DEPTH));
      if (fill != '0) check("inv_busy_when_queued", busy, 1'b1);
    end
  end

  function automatic logic [15:0] rand_op();
    int sel = $urandom_range(0, 9);
    if (sel == 0) return 16'h0000;
    if (sel == 1) return 16'hFFFF;
    return 16'($urandom);
  endfunction

  function automatic logic zero_skip_on();
`ifdef MULT_SEQ_ZERO_SKIP_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_product"}, out_product, 32'd0);
    check({tag, "_mul_a"}, mul_a, 16'd0);
    check({tag, "_mul_b"}, mul_b, 16'd0);
    check({tag, "_mul_clear"}, mul_clear, 1'b0);
    check({tag, "_mul_start"}, mul_start, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_fill"}, fill, 0);
  endtask

  // Returns at 1 time unit after the edge that accepted the pair.
  task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
    int guard = 0;
    while (!in_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("push_ready_timeout", in_ready, 1'b1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_vector(input vec_t v);
    int          cyc;
    int          clears;
    int          starts;
    int          exp_lat;
    int          exp_pulses;
    logic [15:0] a_before;
    logic        zero;
    zero       = (v.a == 16'd0) || (v.b == 16'd0);
    exp_lat    = (zero && zero_skip_on()) ? 2 : L + 4;
    exp_pulses = (zero && zero_skip_on()) ? 0 : 1;
    a_before   = mul_a;
    out_ready  = 1'b0;
    push_pair(v.a, v.b);
    cyc    = 1;
    clears = int'(mul_clear);
    starts = int'(mul_start);
    while (!out_valid && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      clears += int'(mul_clear);
      starts += int'(mul_start);
    end
    check("vec_latency", cyc, exp_lat);
    check("vec_product", out_product, v.prod);
    check("vec_clear_pulses", clears, exp_pulses);
    check("vec_start_pulses", starts, exp_pulses);
    if (zero && zero_skip_on()) check("vec_mul_a_kept", mul_a, a_before);
    repeat (3) @(posedge clk);
    #1;
    check("vec_hold_valid", out_valid, 1'b1);
    check("vec_hold_product", out_product, v.prod);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("vec_valid_drop", out_valid, 1'b0);
    check("vec_busy_idle", busy, 1'b0);
  endtask

  vec_t        vecs[6];
  logic [31:0] sb[$];

  initial begin
    int          cyc;
    int          n;
    int          guard;
    int          pushed;
    int          tcyc[2];
    logic [31:0] prods[2];
    logic [15:0] bp_a[5];
    logic [15:0] bp_b[5];
    logic [31:0] bp_exp[5];
    logic        prev_hold;
    logic [31:0] prev_prod;

    vecs[0] = '{16'd10,    16'd20,    32'd200};
    vecs[1] = '{16'd100,   16'd25,    32'd2500};
    vecs[2] = '{16'd1234,  16'd5678,  32'd7006652};
    vecs[3] = '{16'd0,     16'd777,   32'd0};
    vecs[4] = '{16'd65535, 16'd65535, 32'hFFFE0001};
    vecs[5] = '{16'd3,     16'd4,     32'd12};

    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    reset     = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("init");
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vector(vecs[i]);

    // Back-to-back pair with the consumer always ready.
    @(negedge clk);
    out_ready = 1'b1;
    push_pair(16'd100, 16'd25);
    push_pair(16'd1234, 16'd5678);
    cyc = 2;
    n   = 0;
    while (n < 2 && cyc < 300) begin
      if (out_valid) begin
        tcyc[n]  = cyc;
        prods[n] = out_product;
        n++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    out_ready = 1'b0;
    check("b2b_count", n, 2);
    if (n == 2) begin
      check("b2b_first_latency", tcyc[0], L + 4);
      check("b2b_spacing", tcyc[1] - tcyc[0], L + 4);
      check("b2b_first_product", prods[0], 32'd2500);
      check("b2b_second_product", prods[1], 32'd7006652);
    end

    // Backpressure: five pairs with the consumer stalled.
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      bp_a[i]   = 16'(1000 + 37 * i);
      bp_b[i]   = 16'(3 + 11 * i);
      bp_exp[i] = 32'(bp_a[i]) * 32'(bp_b[i]);
    end
    for (int i = 0; i < 5; i++) push_pair(bp_a[i], bp_b[i]);
    check("bp_fill_full", fill, DEPTH);
    check("bp_in_ready_low", in_ready, 1'b0);
    guard = 0;
    while (!out_valid && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("bp_first_valid", out_valid, 1'b1);
    repeat (10) begin
      @(posedge clk);
      #1;
      check("bp_hold_product", out_product, bp_exp[0]);
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    n = 0;
    guard = 0;
    while (n < 5 && guard < 400) begin
      if (out_valid) begin
        check("bp_drain_product", out_product, bp_exp[n]);
        n++;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    check("bp_drain_count", n, 5);
    out_ready = 1'b0;

    // Randomised traffic against an in-order scoreboard.
    pushed    = 0;
    prev_hold = 1'b0;
    prev_prod = '0;
    for (int c = 0; c < 4000 && (pushed < NRAND || sb.size() > 0); c++) begin
      @(negedge clk);
      if (prev_hold) begin
        check("rand_hold_valid", out_valid, 1'b1);
        check("rand_hold_product", out_product, prev_prod);
      end
      in_valid  = (pushed < NRAND) && ($urandom_range(0, 3) != 0);
      in_a      = rand_op();
      in_b      = rand_op();
      out_ready = ($urandom_range(0, 2) != 0);
      if (in_valid && in_ready) begin
        sb.push_back(32'(in_a) * 32'(in_b));
        pushed++;
      end
      if (out_valid && out_ready) begin
        check("rand_result_expected", sb.size() > 0, 1'b1);
        if (sb.size() > 0) check("rand_product", out_product, sb.pop_front());
      end
      prev_hold = out_valid && !out_ready;
      prev_prod = out_product;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("rand_all_pushed", pushed, NRAND);
    check("rand_all_drained", sb.size(), 0);

    // Reset while a multiplication is in flight and two pairs are queued.
    push_pair(16'd7, 16'd9);
    push_pair(16'd11, 16'd13);
    push_pair(16'd15, 16'd17);
    repeat (10) @(posedge clk);
    #1;
    check("pre_reset_fill", fill, 2);
    check("pre_reset_busy", busy, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      n += int'(out_valid);
    end
    check("post_reset_no_valid", n, 0);
    check("post_reset_fill", fill, 0);
    run_vector(vecs[5]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog_timeout actual=%0d expected=%0d", checks, 0);
    $fatal(1, "[TB] simulation did not finish");
  end

endmodule
